// File: rtl/syn_md_seq_pkg.sv
// rtl/syn_md_seq_pkg.sv - shared types and constants for the syn_md sequencer
package syn_md_seq_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  localparam logic [1:0] MODE_SOFT = 2'd0;
  localparam logic [1:0] MODE_SW1  = 2'd1;
  localparam logic [1:0] MODE_SW2  = 2'd2;
  localparam logic [1:0] MODE_RT   = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/syn_md_seq_ctrl_if.sv
// rtl/syn_md_seq_ctrl_if.sv - command/config/status bundle of the sequencer (SYN_MD_SEQ_REPEAT_EN adds cfg_repeat)
interface syn_md_seq_ctrl_if
  import syn_md_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
);
  logic             start;
  logic             abort;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_period;
  logic [NUM_W-1:0] cfg_count;
`ifdef SYN_MD_SEQ_REPEAT_EN
  logic             cfg_repeat;
`endif
  logic             soft_d;
  logic             sw1;
  logic             sw2;
  logic             rt_sw;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NUM_W-1:0] pulse_idx;

  modport master (
    output start, abort, cfg_mode, cfg_delay, cfg_width, cfg_period, cfg_count,
`ifdef SYN_MD_SEQ_REPEAT_EN
    output cfg_repeat,
`endif
    input  soft_d, sw1, sw2, rt_sw, busy, done, aborted, pulse_idx
  );

  modport slave (
    input  start, abort, cfg_mode, cfg_delay, cfg_width, cfg_period, cfg_count,
`ifdef SYN_MD_SEQ_REPEAT_EN
    input  cfg_repeat,
`endif
    output soft_d, sw1, sw2, rt_sw, busy, done, aborted, pulse_idx
  );

endinterface

// File: rtl/syn_md_seq_timer.sv
// rtl/syn_md_seq_timer.sv - loadable saturating down-counter with zero flag
module syn_md_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  // load wins over counting; the count parks at zero instead of wrapping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/syn_md_seq_ctrl.sv
// rtl/syn_md_seq_ctrl.sv - pulse-train sequencer for the syn_md source lines (option: SYN_MD_SEQ_REPEAT_EN)
module syn_md_seq_ctrl
  import syn_md_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             i_clkin,
  input  logic             i_rst,
  syn_md_seq_ctrl_if.slave io_seq
);
  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_wid_m1;
  logic [CNT_W-1:0] r_low_m1;
  logic [NUM_W-1:0] r_count;
  logic [NUM_W-1:0] r_idx;
  logic [3:0]       r_line;
  logic [3:0]       w_line_d;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             w_accept;
  logic             w_abort;
  logic             w_last;
  logic             w_rep;
  logic             w_zero;
  logic             w_load;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_low;

  // r_busy gate keeps start ignored in the cycle where done is still visible
  assign w_accept = (r_state == IDLE) && io_seq.start && !r_busy;
  assign w_abort  = io_seq.abort && (r_state != IDLE);
  assign w_last   = (r_idx == r_count - NUM_W'(1));
  assign w_tmr_en = (r_state != IDLE);

  // low time is kept instead of period so a full-scale width cannot overflow
  assign w_width = (io_seq.cfg_width == '0) ? CNT_W'(1) : io_seq.cfg_width;
  assign w_low   = (io_seq.cfg_period <= w_width) ? CNT_W'(1) : (io_seq.cfg_period - w_width);

`ifdef SYN_MD_SEQ_REPEAT_EN
  logic r_repeat;

  // repeat flag is part of the shadow configuration
  always_ff @(posedge i_clkin or posedge i_rst) begin
    if (i_rst)
      r_repeat <= 1'b0;
    else if (w_accept)
      r_repeat <= io_seq.cfg_repeat;
  end

  assign w_rep = r_repeat;
`else
  assign w_rep = 1'b0;
`endif

  syn_md_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clkin),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_zero)
  );

  // state register
  always_ff @(posedge i_clkin or posedge i_rst) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // next state plus timer reload on every state entry
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (io_seq.cfg_count == '0) ? DONE : DELAY;
      DELAY:   if (w_zero) w_next = HIGH;
      HIGH:    if (w_zero) w_next = w_last ? (w_rep ? DELAY : DONE) : LOW;
      LOW:     if (w_zero) w_next = HIGH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort)
      w_next = IDLE;
    w_load = (w_next != r_state);
    case (w_next)
      DELAY:   w_load_val = (r_state == IDLE) ? io_seq.cfg_delay : r_delay;
      HIGH:    w_load_val = r_wid_m1;
      LOW:     w_load_val = r_low_m1;
      default: w_load_val = '0;
    endcase
  end

  // shadow config latched on accept, pulse index tracking
  always_ff @(posedge i_clkin or posedge i_rst) begin
    if (i_rst) begin
      r_mode   <= MODE_SOFT;
      r_delay  <= '0;
      r_wid_m1 <= '0;
      r_low_m1 <= '0;
      r_count  <= '0;
      r_idx    <= '0;
    end else if (w_accept) begin
      r_mode   <= io_seq.cfg_mode;
      r_delay  <= io_seq.cfg_delay;
      r_wid_m1 <= w_width - CNT_W'(1);
      r_low_m1 <= w_low - CNT_W'(1);
      r_count  <= io_seq.cfg_count;
      r_idx    <= '0;
    end else if (w_load && (w_next == HIGH) && (r_state == LOW)) begin
      r_idx <= r_idx + NUM_W'(1);
    end else if (w_load && (w_next == DELAY)) begin
      r_idx <= '0;
    end
  end

  // line demux: only the selected line can follow the HIGH state
  always_comb begin
    w_line_d = '0;
    if ((r_state == HIGH) && !w_abort) begin
      case (r_mode)
        MODE_SOFT: w_line_d[0] = 1'b1;
        MODE_SW1:  w_line_d[1] = 1'b1;
        MODE_SW2:  w_line_d[2] = 1'b1;
        MODE_RT:   w_line_d[3] = 1'b1;
        default:   w_line_d    = '0;
      endcase
    end
  end

  // registered outputs, one cycle behind the state they decode
  always_ff @(posedge i_clkin or posedge i_rst) begin
    if (i_rst) begin
      r_line    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_line    <= w_line_d;
      r_busy    <= (r_state != IDLE) && !w_abort;
      r_done    <= (r_state == DONE) && !w_abort;
      r_aborted <= w_abort;
    end
  end

  assign io_seq.soft_d    = r_line[0];
  assign io_seq.sw1       = r_line[1];
  assign io_seq.sw2       = r_line[2];
  assign io_seq.rt_sw     = r_line[3];
  assign io_seq.busy      = r_busy;
  assign io_seq.done      = r_done;
  assign io_seq.aborted   = r_aborted;
  assign io_seq.pulse_idx = r_idx;

endmodule

// File: tb/tb_syn_md_seq_ctrl.sv
// tb/tb_syn_md_seq_ctrl.sv - scoreboard bench for syn_md_seq_ctrl (SYN_MD_SEQ_REPEAT_EN selects repeat case)
module tb_syn_md_seq_ctrl;
  import syn_md_seq_pkg::*;

  typedef struct {
    int         c;
    logic [14:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks;
  int   n_errors;
  bit   mon_en;
  ev_t  sbq[$];
  logic [14:0] last_vec;

  int m_mode, m_d, m_w, m_p, m_cnt, m_T, m_abort, m_end;
  bit m_rep;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syn_md_seq_ctrl_if bus ();

  syn_md_seq_ctrl dut (
    .i_clkin (clk),
    .i_rst   (rst),
    .io_seq  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {rt_sw, sw2, sw1, soft_d, busy, done, aborted, pulse_idx}
  function automatic logic [14:0] cur_vec();
    return {bus.rt_sw, bus.sw2, bus.sw1, bus.soft_d, bus.busy, bus.done, bus.aborted, bus.pulse_idx};
  endfunction

  // selected line's source state is HIGH after edge q (relative to the start edge)
  function automatic bit in_high(int q);
    int y;
    if (q < 0) return 1'b0;
    if (m_rep) q = q % m_T;
    y = q - (m_d + 1);
    if (y < 0) return 1'b0;
    return ((y / m_p) < m_cnt) && ((y % m_p) < m_w);
  endfunction

  function automatic int idx_at(int r);
    int q, j;
    if (r < 0 || m_cnt == 0) return 0;
    q = m_rep ? (r % m_T) : r;
    if (q < m_d + 1) return 0;
    j = (q - m_d - 1) / m_p;
    return (j > m_cnt - 1) ? (m_cnt - 1) : j;
  endfunction

  function automatic logic [14:0] model_vec(int r);
    logic [3:0] ln;
    logic b, dn, ab;
    int ix;
    ln = '0; b = 1'b0; dn = 1'b0; ab = 1'b0;
    if (m_abort >= 0 && r >= m_abort) begin
      ab = (r == m_abort);
      ix = idx_at(m_abort - 1);
    end else begin
      ix = idx_at(r);
      if (m_rep) b = (r >= 1);
      else begin
        b  = (r >= 1) && (r <= m_end);
        dn = (r == m_end);
      end
      if (m_cnt > 0 && in_high(r - 1)) ln[m_mode] = 1'b1;
    end
    return {ln, b, dn, ab, ix[7:0]};
  endfunction

  task automatic monitor();
    logic [14:0] v;
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        v = cur_vec();
        if (v !== last_vec) begin
          if (sbq.size() == 0) check("unexp_chg", 32'(v), 32'(last_vec));
          else begin
            e = sbq.pop_front();
            check("ev_cyc", cyc, e.c);
            check("ev_vec", 32'(v), 32'(e.v));
          end
          last_vec = v;
        end
      end
    end
  endtask

  task automatic run(input int mode, input int d, input int w, input int p, input int cnt,
                     input bit rep, input int ab_at, input bit disturb);
    int s, limit, rel;
    logic [14:0] prev, v;
    m_mode  = mode;
    m_d     = d;
    m_w     = (w == 0) ? 1 : w;
    m_p     = (p <= m_w) ? m_w + 1 : p;
    m_cnt   = cnt;
`ifdef SYN_MD_SEQ_REPEAT_EN
    m_rep   = rep;
`else
    m_rep   = 1'b0;
`endif
    m_T     = m_d + 1 + (m_cnt - 1) * m_p + m_w;
    m_end   = (cnt == 0) ? 1 : m_d + 1 + (m_cnt - 1) * m_p + m_w + 1;
    m_abort = ab_at;
    limit   = (ab_at >= 0) ? ab_at + 1 : m_end + 1;
    @(negedge clk);
    bus.cfg_mode   = mode[1:0];
    bus.cfg_delay  = d[15:0];
    bus.cfg_width  = w[15:0];
    bus.cfg_period = p[15:0];
    bus.cfg_count  = cnt[7:0];
`ifdef SYN_MD_SEQ_REPEAT_EN
    bus.cfg_repeat = rep;
`endif
    bus.start = 1'b1;
    s = cyc + 1;
    prev = last_vec;
    for (int r = 0; r <= limit; r++) begin
      v = model_vec(r);
      if (v !== prev) sbq.push_back('{s + r, v});
      prev = v;
    end
    while (cyc < s + limit + 3) begin
      @(negedge clk);
      rel = cyc + 1 - s;
      bus.abort = (ab_at >= 0) && (rel == ab_at);
      bus.start = disturb && (rel == 3 || rel == 12 || rel == m_end || rel == m_end + 1);
      if (bus.start) begin
        bus.cfg_mode   = MODE_SW2;
        bus.cfg_delay  = 16'd0;
        bus.cfg_width  = 16'd1;
        bus.cfg_period = 16'd2;
        bus.cfg_count  = 8'd7;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sb_drain", sbq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_mode = 2'd0;
    bus.cfg_delay = '0;
    bus.cfg_width = '0;
    bus.cfg_period = '0;
    bus.cfg_count = '0;
`ifdef SYN_MD_SEQ_REPEAT_EN
    bus.cfg_repeat = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vec", 32'(cur_vec()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_vec", 32'(cur_vec()), 32'd0);
    last_vec = cur_vec();
    mon_en = 1'b1;
    fork
      monitor();
    join_none

    run(1, 3, 4, 10, 3, 1'b0, -1, 1'b0);
    run(0, 5, 2, 3, 0, 1'b0, -1, 1'b0);
    run(3, 0, 0, 0, 2, 1'b0, -1, 1'b0);
    run(2, 2, 3, 6, 3, 1'b0, 11, 1'b0);
    run(1, 2, 2, 5, 3, 1'b0, -1, 1'b1);

    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_abort", 32'(cur_vec()), 32'(last_vec));

`ifdef SYN_MD_SEQ_REPEAT_EN
    run(0, 1, 2, 4, 2, 1'b1, 19, 1'b0);
`else
    run(0, 1, 2, 4, 2, 1'b0, -1, 1'b0);
`endif

    mon_en = 1'b0;
    @(negedge clk);
    bus.cfg_mode = MODE_SW1;
    bus.cfg_delay = 16'd1;
    bus.cfg_width = 16'd4;
    bus.cfg_period = 16'd6;
    bus.cfg_count = 8'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_sw1", 32'(bus.sw1), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_vec", 32'(cur_vec()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_pulse", {30'd0, bus.done, bus.aborted}, 32'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_stays_idle", 32'(cur_vec()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
